// File: rtl/gather_switch.sv
`default_nettype none
// ============================================================================
// Module      : gather_switch
// Description : Upsizing return-path switch. Packs 1536/256/128-bit stream
//               beats LSB-first into 1536-bit words for one of five sinks.
// Revision    : 1.0 - initial release
// ============================================================================
module gather_switch #(
    parameter int DWIDTH = 1536,
    parameter int NW1    = 256,
    parameter int NW2    = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        ctrl,
    input  logic              flush,
    output logic              idle,
    input  logic [DWIDTH-1:0] s_in_w_tdata,
    input  logic              s_in_w_tvalid,
    output logic              s_in_w_tready,
    input  logic [NW1-1:0]    s_in_n1_tdata,
    input  logic              s_in_n1_tvalid,
    output logic              s_in_n1_tready,
    input  logic [NW2-1:0]    s_in_n2_tdata,
    input  logic              s_in_n2_tvalid,
    output logic              s_in_n2_tready,
    output logic [DWIDTH-1:0] m_out,
    output logic              m_out_a_tvalid,
    input  logic              m_out_a_tready,
    output logic              m_out_b_tvalid,
    input  logic              m_out_b_tready,
    output logic              m_out_c_tvalid,
    input  logic              m_out_c_tready,
    output logic              m_out_d_tvalid,
    input  logic              m_out_d_tready,
    output logic              m_out_e_tvalid,
    input  logic              m_out_e_tready
);

    localparam int         c_N1       = DWIDTH / NW1;
    localparam int         c_N2       = DWIDTH / NW2;
    localparam logic [1:0] c_SRC_W    = 2'd0;
    localparam logic [1:0] c_SRC_N1   = 2'd1;
    localparam logic [1:0] c_SRC_N2   = 2'd2;
    localparam logic [1:0] c_SRC_NONE = 2'd3;
    localparam logic [2:0] c_DST_NONE = 3'd7;

    logic [1:0]        w_src;
    logic [2:0]        w_dst;
    logic              w_dst_ready;
    logic              w_src_ready;
    logic              w_src_valid;
    logic [3:0]        w_last_idx;
    logic              w_take;
    logic              w_wrap;
    logic [DWIDTH-1:0] w_pack_next;

    logic [DWIDTH-1:0] r_pack;
    logic [3:0]        r_count;
    logic              r_full;

    // While reset is held the routing resolves to "none" so no tready leaks out.
    assign w_src = rst_n ? ctrl[1:0] : c_SRC_NONE;
    assign w_dst = rst_n ? ctrl[4:2] : c_DST_NONE;

    always_comb begin
        w_dst_ready = 1'b0;
        case (w_dst)
            3'd0:    w_dst_ready = m_out_a_tready;
            3'd1:    w_dst_ready = m_out_b_tready;
            3'd2:    w_dst_ready = m_out_c_tready;
            3'd3:    w_dst_ready = m_out_d_tready;
            3'd4:    w_dst_ready = m_out_e_tready;
            default: w_dst_ready = 1'b0;
        endcase
    end

    assign w_src_ready = ~r_full | w_dst_ready;

    always_comb begin
        w_src_valid = 1'b0;
        w_last_idx  = 4'd0;
        case (w_src)
            c_SRC_W: begin
                w_src_valid = s_in_w_tvalid;
                w_last_idx  = 4'd0;
            end
            c_SRC_N1: begin
                w_src_valid = s_in_n1_tvalid;
                w_last_idx  = 4'(c_N1 - 1);
            end
            c_SRC_N2: begin
                w_src_valid = s_in_n2_tvalid;
                w_last_idx  = 4'(c_N2 - 1);
            end
            default: begin
                w_src_valid = 1'b0;
                w_last_idx  = 4'd0;
            end
        endcase
    end

    assign s_in_w_tready  = (w_src == c_SRC_W)  & w_src_ready;
    assign s_in_n1_tready = (w_src == c_SRC_N1) & w_src_ready;
    assign s_in_n2_tready = (w_src == c_SRC_N2) & w_src_ready;

    // A flushed beat is still handshaken but never lands in the word.
    assign w_take = w_src_valid & w_src_ready & ~flush;
    assign w_wrap = w_take & (r_count == w_last_idx);

    always_comb begin
        w_pack_next = r_pack;
        if (w_take) begin
            case (w_src)
                c_SRC_W:  w_pack_next = s_in_w_tdata;
                c_SRC_N1: begin
                    for (int k = 0; k < c_N1; k++) begin
                        if (r_count == 4'(k)) w_pack_next[k*NW1 +: NW1] = s_in_n1_tdata;
                    end
                end
                c_SRC_N2: begin
                    for (int k = 0; k < c_N2; k++) begin
                        if (r_count == 4'(k)) w_pack_next[k*NW2 +: NW2] = s_in_n2_tdata;
                    end
                end
                default: w_pack_next = r_pack;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pack  <= '0;
            r_count <= 4'd0;
            r_full  <= 1'b0;
        end else begin
            r_pack <= w_pack_next;
            if (flush) begin
                r_count <= 4'd0;
            end else if (w_take) begin
                r_count <= w_wrap ? 4'd0 : r_count + 4'd1;
            end
            // A completing beat re-arms full even while the previous word drains.
            if (w_wrap) begin
                r_full <= 1'b1;
            end else if (r_full & w_dst_ready) begin
                r_full <= 1'b0;
            end
        end
    end

    assign m_out          = r_pack;
    assign m_out_a_tvalid = r_full & (w_dst == 3'd0);
    assign m_out_b_tvalid = r_full & (w_dst == 3'd1);
    assign m_out_c_tvalid = r_full & (w_dst == 3'd2);
    assign m_out_d_tvalid = r_full & (w_dst == 3'd3);
    assign m_out_e_tvalid = r_full & (w_dst == 3'd4);
    assign idle           = (r_count == 4'd0) & ~r_full;

endmodule
`default_nettype wire

// File: tb/tb_gather_switch.sv
`default_nettype none
// ============================================================================
// Module      : tb_gather_switch
// Description : Scoreboard bench for gather_switch with a beat-packing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gather_switch;
    localparam int DW = 1536;
    localparam int W1 = 256;
    localparam int W2 = 128;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    ctrl;
    logic          flush;
    logic          idle;
    logic [DW-1:0] w_tdata;
    logic          w_tvalid, w_tready;
    logic [W1-1:0] n1_tdata;
    logic          n1_tvalid, n1_tready;
    logic [W2-1:0] n2_tdata;
    logic          n2_tvalid, n2_tready;
    logic [DW-1:0] m_out;
    logic [4:0]    tv;
    logic [4:0]    tr;

    always #5 clk = ~clk;

    gather_switch #(.DWIDTH(DW), .NW1(W1), .NW2(W2)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .flush(flush), .idle(idle),
        .s_in_w_tdata(w_tdata), .s_in_w_tvalid(w_tvalid), .s_in_w_tready(w_tready),
        .s_in_n1_tdata(n1_tdata), .s_in_n1_tvalid(n1_tvalid), .s_in_n1_tready(n1_tready),
        .s_in_n2_tdata(n2_tdata), .s_in_n2_tvalid(n2_tvalid), .s_in_n2_tready(n2_tready),
        .m_out(m_out),
        .m_out_a_tvalid(tv[0]), .m_out_a_tready(tr[0]),
        .m_out_b_tvalid(tv[1]), .m_out_b_tready(tr[1]),
        .m_out_c_tvalid(tv[2]), .m_out_c_tready(tr[2]),
        .m_out_d_tvalid(tv[3]), .m_out_d_tready(tr[3]),
        .m_out_e_tvalid(tv[4]), .m_out_e_tready(tr[4])
    );

    typedef struct {
        logic [DW-1:0] word;
        int            dst;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            nchk = 0;
    int            nerr = 0;
    int            n_out = 0;
    int            m_cnt = 0;
    logic [DW-1:0] m_word = '0;
    bit            rr_mode = 1'b0;
    logic [4:0]    prev_ctrl = 5'b11111;
    logic          prev_idle = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic word_check(input logic [DW-1:0] act, input logic [DW-1:0] exp,
                              input int act_dst, input int exp_dst);
        nchk++;
        if (act !== exp || act_dst != exp_dst) begin
            nerr++;
            for (int l = 0; l < DW / W2; l++) begin
                if (act[l*W2 +: W2] !== exp[l*W2 +: W2] || l == DW / W2 - 1) begin
                    $display("FAIL out_word lane %0d: actual %h required %h (dst actual %0d required %0d)",
                             l, act[l*W2 +: W2], exp[l*W2 +: W2], act_dst, exp_dst);
                    break;
                end
            end
        end
    endtask

    function automatic int beats(input int src);
        return (src == 0) ? 1 : (src == 1) ? DW / W1 : DW / W2;
    endfunction

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic src_ready(input int src);
        return (src == 0) ? w_tready : (src == 1) ? n1_tready : n2_tready;
    endfunction

    // Reference: accepted beats fill lanes in arrival order; N beats make a word.
    task automatic model_beat(input int src, input logic [DW-1:0] d, input bit fl);
        if (fl) begin
            m_cnt = 0;
        end else begin
            case (src)
                0:       m_word = d;
                1:       m_word[m_cnt*W1 +: W1] = d[W1-1:0];
                default: m_word[m_cnt*W2 +: W2] = d[W2-1:0];
            endcase
            m_cnt++;
            if (m_cnt == beats(src)) begin
                exp_q.push_back('{word: m_word, dst: int'(ctrl[4:2])});
                m_cnt = 0;
            end
        end
    endtask

    task automatic send(input int src, input logic [DW-1:0] d, input bit fl, output int stalls);
        bit ok;
        ok     = 1'b0;
        stalls = 0;
        flush  = fl;
        case (src)
            0:       begin w_tdata  = d;          w_tvalid  = 1'b1; end
            1:       begin n1_tdata = d[W1-1:0];  n1_tvalid = 1'b1; end
            default: begin n2_tdata = d[W2-1:0];  n2_tvalid = 1'b1; end
        endcase
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (src_ready(src)) ok = 1'b1;
            else stalls++;
            @(posedge clk);
            #1;
        end
        if (ok) model_beat(src, d, fl);
        else begin
            nchk++;
            nerr++;
            $display("FAIL send_timeout: src %0d never ready, actual 0 required 1", src);
        end
        w_tvalid  = 1'b0;
        n1_tvalid = 1'b0;
        n2_tvalid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0) done = 1'b1;
        end
        @(posedge clk);
        #1;
        check(name, done, 1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_idle", idle, 1);
        check("rst_tvalid", tv, 0);
        check("rst_tready", {w_tready, n1_tready, n2_tready}, 0);
        check("rst_mout_zero", |m_out, 0);
        exp_q.delete();
        m_cnt = 0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Scoreboard monitor: pops one expected word per output handshake.
    always @(negedge clk) begin
        if (ctrl !== prev_ctrl) check("ctrl_change_while_idle", prev_idle, 1);
        prev_ctrl = ctrl;
        prev_idle = idle;
        if (rst_n === 1'b1) begin
            for (int x = 0; x < 5; x++) begin
                if (tv[x]) begin
                    check("tvalid_dst", x, ctrl[4:2]);
                    if (tr[x]) begin
                        if (exp_q.size() == 0) begin
                            nchk++;
                            nerr++;
                            $display("FAIL unexpected_word: dst %0d, actual 1 word required 0", x);
                        end else begin
                            mon_e = exp_q.pop_front();
                            word_check(m_out, mon_e.word, x, mon_e.dst);
                            n_out++;
                        end
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rr_mode) tr = 5'($urandom);
    end

    initial begin
        int st;
        int tot;
        int n0;
        rst_n     = 1'b0;
        ctrl      = {3'd0, 2'd2};
        flush     = 1'b0;
        w_tdata   = '0;
        n1_tdata  = '0;
        n2_tdata  = '0;
        w_tvalid  = 1'b1;
        n1_tvalid = 1'b1;
        n2_tvalid = 1'b1;
        tr        = 5'b11111;
        #12;
        check("init_idle", idle, 1);
        check("init_tready", {w_tready, n1_tready, n2_tready}, 0);
        check("init_tvalid", tv, 0);
        check("init_mout_zero", |m_out, 0);
        w_tvalid  = 1'b0;
        n1_tvalid = 1'b0;
        n2_tvalid = 1'b0;
        prev_ctrl = ctrl;
        tick();
        rst_n = 1'b1;
        tick();

        // 128-bit source, lane k = k, valid on the cycle after beat 11
        for (int i = 0; i < 12; i++) send(2, DW'(i), 1'b0, st);
        check("n2_latency_tvalid_a", tv[0], 1);
        wait_drain("n2_drain");

        // 256-bit source into a back-pressured sink
        ctrl = {3'd2, 2'd1};
        tr   = 5'b00000;
        tick();
        for (int i = 0; i < 6; i++) send(1, DW'(32'hA0 + i), 1'b0, st);
        n1_tdata  = W1'(32'hA6);
        n1_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("n1_hold_tready", n1_tready, 0);
            check("n1_hold_tvalid_c", tv[2], 1);
            tick();
        end
        tr = 5'b00100;
        send(1, DW'(32'hA6), 1'b0, st);
        check("n1_drain_stalls", st, 0);
        for (int i = 7; i < 12; i++) send(1, DW'(32'hA0 + i), 1'b0, st);
        wait_drain("n1_drain");

        // wide source, back-to-back
        ctrl = {3'd4, 2'd0};
        tr   = 5'b10000;
        tick();
        n0  = n_out;
        tot = 0;
        for (int i = 0; i < 20; i++) begin
            send(0, rnd_word(), 1'b0, st);
            tot += st;
            if (i == 0) check("wide_latency_tvalid_e", tv[4], 1);
        end
        check("wide_stalls", tot, 0);
        tick();
        tick();
        check("wide_words_out", n_out - n0, 20);
        wait_drain("wide_drain");

        // flush drops beat 6 and the partial word
        ctrl = {3'd1, 2'd2};
        tr   = 5'b00010;
        tick();
        for (int i = 0; i < 5; i++) send(2, rnd_word(), 1'b0, st);
        send(2, DW'(32'hFF), 1'b1, st);
        check("flush_idle", idle, 1);
        for (int i = 0; i < 12; i++) send(2, DW'(32'h10 + i), 1'b0, st);
        wait_drain("flush_drain");
        check("flush_lane0", m_out[63:0], 64'h10);

        // no destination: word completes, then sources stall and nothing is valid
        ctrl = {3'd7, 2'd2};
        tick();
        for (int i = 0; i < 12; i++) send(2, rnd_word(), 1'b0, st);
        n2_tvalid = 1'b1;
        @(negedge clk);
        check("dstnone_tready", n2_tready, 0);
        check("dstnone_tvalid", tv, 0);
        check("dstnone_busy", idle, 0);
        tick();
        n2_tvalid = 1'b0;
        do_reset();

        // all-none routing with stimulus applied
        ctrl = 5'b11111;
        tick();
        w_tvalid  = 1'b1;
        n1_tvalid = 1'b1;
        n2_tvalid = 1'b1;
        @(negedge clk);
        check("none_tready", {w_tready, n1_tready, n2_tready}, 0);
        check("none_tvalid", tv, 0);
        tick();
        w_tvalid  = 1'b0;
        n1_tvalid = 1'b0;
        n2_tvalid = 1'b0;
        tick();

        // reset mid-word, then a full word from lane 0
        ctrl = {3'd3, 2'd1};
        tr   = 5'b01000;
        tick();
        for (int i = 0; i < 3; i++) send(1, rnd_word(), 1'b0, st);
        do_reset();
        for (int i = 0; i < 6; i++) send(1, DW'(32'hC0 + i), 1'b0, st);
        check("post_reset_tvalid_d", tv[3], 1);
        wait_drain("post_reset_drain");

        // randomized rounds
        rr_mode = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int src;
            int dst;
            int nb;
            src  = $urandom_range(0, 2);
            dst  = $urandom_range(0, 4);
            ctrl = {3'(dst), 2'(src)};
            tick();
            nb = beats(src) * $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 2) == 0) tick();
                send(src, rnd_word(), ($urandom_range(0, 15) == 0), st);
            end
            if (m_cnt != 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                m_cnt = 0;
            end
            wait_drain("random_drain");
        end

        check("final_queue_empty", exp_q.size(), 0);
        check("final_idle", idle, 1);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
